// File: rtl/serial_slave_port.sv
// serial_slave_port: bit-serial bus slave with a local register file.
// Accepts start/rw/addr[/data] request frames on rx and returns read data
// on tx as start bit plus LSB-first data. A busy input parks a decoded
// access in HOLD so the arbiter can serve the other master meanwhile.
module serial_slave_port #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx,
    input  logic busy,
    output logic ready,
    output logic split,
    output logic responded
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CW    = $clog2(MAXW + 1);

    typedef enum logic [2:0] {
        IDLE,
        RW,
        ADDR,
        WDATA,
        HOLD,
        RSTART,
        RDATA
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    tx_q, tx_d;
    logic                    ready_q, ready_d;
    logic                    split_q, split_d;
    logic                    responded_q, responded_d;
    logic                    wr_pend_q, wr_pend_d;
    logic                    mem_we_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign tx        = tx_q;
    assign ready     = ready_q;
    assign split     = split_q;
    assign responded = responded_q;

    // State and datapath registers; memory is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shreg_q     <= '0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
            split_q     <= 1'b0;
            responded_q <= 1'b0;
            wr_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            ready_q     <= ready_d;
            split_q     <= split_d;
            responded_q <= responded_d;
            wr_pend_q   <= wr_pend_d;
        end
    end

    // Register-file write port, committed when a parked write is released.
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        shreg_d     = shreg_q;
        tx_d        = 1'b1;
        split_d     = 1'b0;
        responded_d = wr_pend_q;
        wr_pend_d   = 1'b0;
        mem_we_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d = RW;
                end
            end
            RW: begin
                rw_d    = rx;
                cnt_d   = '0;
                state_d = ADDR;
            end
            ADDR: begin
                addr_d = {rx, addr_q[ADDR_WIDTH-1:1]};
                if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = rw_q ? WDATA : HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WDATA: begin
                wdata_d = {rx, wdata_q[DATA_WIDTH-1:1]};
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (busy) begin
                    split_d = 1'b1;
                end else if (rw_q) begin
                    mem_we_c  = 1'b1;
                    wr_pend_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    shreg_d = mem[addr_q];
                    cnt_d   = '0;
                    state_d = RSTART;
                end
            end
            RSTART: begin
                tx_d    = 1'b0;
                state_d = RDATA;
            end
            RDATA: begin
                if (cnt_q == CW'(DATA_WIDTH)) begin
                    responded_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

endmodule
